// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, PC-source
// codes, the bubble instruction and the default reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ     = 2'b00,
        S_DISCARD = 2'b01,
        S_HELD    = 2'b10
    } fetch_state_t;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Instruction addresses are word aligned; drop the byte offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither asserted the
// register holds its contents.
import cpu_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        valid
);

    logic [31:0] pc_reg;
    logic [31:0] pc4_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;

    // Register update: reset and bubble clear to an invalid NOP, load captures.
    always_ff @(posedge clk) begin
        if (srst || bubble) begin
            pc_reg    <= 32'h0000_0000;
            pc4_reg   <= 32'h0000_0000;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= pc_in;
            pc4_reg   <= pc4_in;
            instr_reg <= instr_in;
            valid_reg <= 1'b1;
        end
    end

    assign pc    = pc_reg;
    assign pc4   = pc4_reg;
    assign instr = instr_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues fetch requests, handles
// redirects that arrive while a request is outstanding (S_DISCARD) and
// parks a fetched word in a skid buffer while the pipeline is stalled (S_HELD).
import cpu_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iBlockPC,
    input  logic        iBlockIFID,
    input  logic [1:0]  iPCSrc,
    input  logic [31:0] iBranchTarget,
    input  logic [31:0] iJumpTarget,
    input  logic [31:0] iJrTarget,
    output logic [31:0] oIMemAddr,
    output logic        oIMemReq,
    input  logic        iIMemReady,
    input  logic [31:0] iIMemData,
    output logic [31:0] oIF_ID_PC,
    output logic [31:0] oIF_ID_PC4,
    output logic [31:0] oIF_ID_Instr,
    output logic        oIF_ID_Valid,
    output logic [31:0] oPC
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pending_reg, pending_next;
    logic [31:0]  buf_reg, buf_next;

    logic         stall;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr;

    assign stall    = iBlockPC | iBlockIFID;
    assign redirect = (iPCSrc != PCSRC_PC4) && !stall;
    assign pc_plus4 = pc_reg + 32'd4;

    // Next-PC target mux for the three redirect sources.
    always_comb begin
        target = align_word(pc_plus4);
        case (iPCSrc)
            PCSRC_BR: target = align_word(iBranchTarget);
            PCSRC_J:  target = align_word(iJumpTarget);
            PCSRC_JR: target = align_word(iJrTarget);
            default:  target = align_word(pc_plus4);
        endcase
    end

    // State, PC, pending-target and skid-buffer registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg   <= S_REQ;
            pc_reg      <= RESET_PC;
            pending_reg <= 32'h0000_0000;
            buf_reg     <= 32'h0000_0000;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pending_reg <= pending_next;
            buf_reg     <= buf_next;
        end
    end

    // Fetch FSM: next state, next PC and IF/ID control.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pending_next = pending_reg;
        buf_next     = buf_reg;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = iIMemData;

        case (state_reg)
            S_REQ: begin
                if (iIMemReady) begin
                    if (redirect) begin
                        // Wrong-path word: drop it and restart at the target.
                        ifid_bubble = 1'b1;
                        pc_next     = target;
                    end else if (stall) begin
                        // Word arrived but pipeline is frozen; park it.
                        buf_next   = iIMemData;
                        state_next = S_HELD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_next   = pc_plus4;
                    end
                end else begin
                    if (redirect) begin
                        // Request in flight cannot be withdrawn; remember
                        // where to go once its response has been absorbed.
                        pending_next = target;
                        ifid_bubble  = 1'b1;
                        state_next   = S_DISCARD;
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
            end

            S_DISCARD: begin
                if (!stall) begin
                    ifid_bubble = 1'b1;
                end
                if (redirect) begin
                    pending_next = target;
                end
                if (iIMemReady) begin
                    pc_next    = redirect ? target : pending_reg;
                    state_next = S_REQ;
                end
            end

            S_HELD: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_next     = target;
                    state_next  = S_REQ;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_reg;
                    pc_next    = pc_plus4;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (iCLK),
        .srst     (iRST),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (pc_reg),
        .pc4_in   (pc_plus4),
        .instr_in (ifid_instr),
        .pc       (oIF_ID_PC),
        .pc4      (oIF_ID_PC4),
        .instr    (oIF_ID_Instr),
        .valid    (oIF_ID_Valid)
    );

    assign oIMemReq  = (state_reg != S_HELD);
    assign oIMemAddr = pc_reg;
    assign oPC       = pc_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with hand-computed expected values.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        block_pc;
    logic        block_ifid;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] pc;

    int vec_count = 0;
    int err_count = 0;

    if_fetch_stage dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iBlockPC      (block_pc),
        .iBlockIFID    (block_ifid),
        .iPCSrc        (pc_src),
        .iBranchTarget (branch_target),
        .iJumpTarget   (jump_target),
        .iJrTarget     (jr_target),
        .oIMemAddr     (imem_addr),
        .oIMemReq      (imem_req),
        .iIMemReady    (imem_ready),
        .iIMemData     (imem_data),
        .oIF_ID_PC     (ifid_pc),
        .oIF_ID_PC4    (ifid_pc4),
        .oIF_ID_Instr  (ifid_instr),
        .oIF_ID_Valid  (ifid_valid),
        .oPC           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t addr=%08h req=%0b ifid pc=%08h pc4=%08h instr=%08h v=%0b",
                 $time, imem_addr, imem_req, ifid_pc, ifid_pc4, ifid_instr, ifid_valid);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] epc, input logic [31:0] epc4,
                              input logic [31:0] einstr, input logic evalid);
        check({tag, "_pc"}, ifid_pc, epc);
        check({tag, "_pc4"}, ifid_pc4, epc4);
        check({tag, "_instr"}, ifid_instr, einstr);
        check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, evalid});
    endtask

    initial begin
        rst = 1'b1; block_pc = 1'b0; block_ifid = 1'b0; pc_src = 2'b00;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
        imem_ready = 1'b0; imem_data = 32'h0;
        step(); step();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_addr", imem_addr, 32'h0040_0000);
        check("rst_req", {31'd0, imem_req}, 32'd1);
        check_ifid("rst_ifid", 32'h0, 32'h0, 32'h0, 1'b0);

        // Sequential fetch, ready tied high.
        imem_ready = 1'b1; imem_data = 32'hA000_0000;
        step();
        check("seq0_addr", imem_addr, 32'h0040_0004);
        check_ifid("seq0", 32'h0040_0000, 32'h0040_0004, 32'hA000_0000, 1'b1);
        imem_data = 32'hA000_0001;
        step();
        check("seq1_addr", imem_addr, 32'h0040_0008);
        check_ifid("seq1", 32'h0040_0004, 32'h0040_0008, 32'hA000_0001, 1'b1);
        imem_data = 32'hA000_0002;
        step();
        check("seq2_addr", imem_addr, 32'h0040_000C);
        check_ifid("seq2", 32'h0040_0008, 32'h0040_000C, 32'hA000_0002, 1'b1);

        // Branch taken with ready: bubble, fetch target.
        pc_src = 2'b01; branch_target = 32'h0040_0100; imem_data = 32'hBAD0_0000;
        step();
        pc_src = 2'b00;
        check("br_addr", imem_addr, 32'h0040_0100);
        check_ifid("br", 32'h0, 32'h0, 32'h0, 1'b0);

        // Memory wait: address and PC stable, bubbles.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr", imem_addr, 32'h0040_0100);
            check("wait_pc", pc, 32'h0040_0100);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_valid", {31'd0, ifid_valid}, 32'd0);
        end
        imem_ready = 1'b1; imem_data = 32'h8C08_0004;
        step();
        check("late_addr", imem_addr, 32'h0040_0104);
        check_ifid("late", 32'h0040_0100, 32'h0040_0104, 32'h8C08_0004, 1'b1);

        // jr while waiting: late response dropped.
        imem_ready = 1'b0; pc_src = 2'b11; jr_target = 32'h0040_0040;
        step();
        pc_src = 2'b00;
        check("jr_wait_addr", imem_addr, 32'h0040_0104);
        check("jr_wait_req", {31'd0, imem_req}, 32'd1);
        check_ifid("jr_wait", 32'h0, 32'h0, 32'h0, 1'b0);
        imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
        step();
        check("jr_drop_addr", imem_addr, 32'h0040_0040);
        check_ifid("jr_drop", 32'h0, 32'h0, 32'h0, 1'b0);
        imem_data = 32'hC000_0000;
        step();
        check_ifid("jr_fetch", 32'h0040_0040, 32'h0040_0044, 32'hC000_0000, 1'b1);

        // Two redirects while waiting: the latest target wins.
        imem_ready = 1'b0; pc_src = 2'b10; jump_target = 32'h0040_0200;
        step();
        pc_src = 2'b01; branch_target = 32'h0040_0300;
        step();
        check("dbl_hold_addr", imem_addr, 32'h0040_0044);
        pc_src = 2'b00; imem_ready = 1'b1; imem_data = 32'hDEAD_0001;
        step();
        check("dbl_addr", imem_addr, 32'h0040_0300);
        check("dbl_valid", {31'd0, ifid_valid}, 32'd0);

        // Misaligned jump target has its low bits cleared.
        pc_src = 2'b10; jump_target = 32'h0040_0207;
        step();
        pc_src = 2'b00;
        check("align_addr", imem_addr, 32'h0040_0204);

        // Stall on the ready cycle: word parked, everything frozen.
        imem_data = 32'h1234_5678; block_pc = 1'b1;
        step();
        check("held_req", {31'd0, imem_req}, 32'd0);
        check("held_pc", pc, 32'h0040_0204);
        check("held_valid", {31'd0, ifid_valid}, 32'd0);
        // Redirect during stall is ignored.
        imem_ready = 1'b0; pc_src = 2'b01; branch_target = 32'h0050_0000;
        step();
        check("held2_req", {31'd0, imem_req}, 32'd0);
        check("held2_pc", pc, 32'h0040_0204);
        check("held2_valid", {31'd0, ifid_valid}, 32'd0);
        block_pc = 1'b0; pc_src = 2'b00;
        step();
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_pc", pc, 32'h0040_0208);
        check_ifid("rel", 32'h0040_0204, 32'h0040_0208, 32'h1234_5678, 1'b1);

        // Reset while holding a parked word.
        imem_ready = 1'b1; imem_data = 32'hAAAA_0000; block_ifid = 1'b1;
        step();
        check("held3_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0; block_ifid = 1'b0; imem_ready = 1'b0;
        check("rst2_req", {31'd0, imem_req}, 32'd1);
        check("rst2_pc", pc, 32'h0040_0000);
        check("rst2_valid", {31'd0, ifid_valid}, 32'd0);

        // PC wraps modulo 2^32.
        imem_ready = 1'b1; pc_src = 2'b10; jump_target = 32'hFFFF_FFFC;
        step();
        pc_src = 2'b00;
        check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        imem_data = 32'h0BAD_F00D;
        step();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check_ifid("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 32'h0BAD_F00D, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
